instr_queue: RTL and testbench

INSTR_QUEUE -- requirements
Module: instr_queue

---
 rtl/instr_queue.sv | 142 ++++++++++++++
 tb/tb_instr_queue.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/instr_queue.sv
// Dual-issue instruction queue: circular buffer accepting up to two fetched
// instructions per cycle and presenting the two oldest entries to the decoders.
module instr_queue #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [1:0]                   push_valid,
  input  logic [31:0]                  push_instr0,
  input  logic [31:0]                  push_instr1,
  input  logic [31:0]                  push_pc0,
  input  logic [31:0]                  push_pc1,
  output logic                         push_ready,
  output logic [1:0]                   out_valid,
  output logic [31:0]                  out_instr0,
  output logic [31:0]                  out_instr1,
  output logic [31:0]                  out_pc0,
  output logic [31:0]                  out_pc1,
  input  logic [1:0]                   pop_num,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:0]      instr_mem [DEPTH];
  logic [31:0]      pc_mem    [DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic [PTR_W-1:0] head_next, tail_next, tail_p1, rd0, rd1;
  logic [CNT_W-1:0] count_next;
  logic [1:0]       n_push, n_pop, pop_req;
  logic             wr0, wr1;
  logic [31:0]      rd_instr0, rd_instr1, rd_pc0, rd_pc1;

  // Next pointers/occupancy; flush wins over any push or pop in the same cycle.
  always_comb begin
    n_push     = 2'd0;
    wr0        = 1'b0;
    wr1        = 1'b0;
    pop_req    = (pop_num == 2'b11) ? 2'd2 : pop_num;
    n_pop      = (CNT_W'(pop_req) > count) ? 2'(count) : pop_req;
    tail_p1    = tail + PTR_W'(1);
    head_next  = head;
    tail_next  = tail;
    count_next = count;
    if (push_ready) begin
      if (push_valid == 2'b11) begin
        n_push = 2'd2;
        wr0    = 1'b1;
        wr1    = 1'b1;
      end else if (push_valid == 2'b01) begin
        n_push = 2'd1;
        wr0    = 1'b1;
      end
    end
    if (flush) begin
      wr0        = 1'b0;
      wr1        = 1'b0;
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      head_next  = head + PTR_W'(n_pop);
      tail_next  = tail + PTR_W'(n_push);
      count_next = count + CNT_W'(n_push) - CNT_W'(n_pop);
    end
  end

  // Next-cycle head entries; entries written this cycle are forwarded into the
  // output registers so they appear one cycle after the push.
  always_comb begin
    rd0       = head_next;
    rd1       = head_next + PTR_W'(1);
    rd_instr0 = instr_mem[rd0];
    rd_pc0    = pc_mem[rd0];
    rd_instr1 = instr_mem[rd1];
    rd_pc1    = pc_mem[rd1];
    if (wr0 && rd0 == tail) begin
      rd_instr0 = push_instr0;
      rd_pc0    = push_pc0;
    end else if (wr1 && rd0 == tail_p1) begin
      rd_instr0 = push_instr1;
      rd_pc0    = push_pc1;
    end
    if (wr0 && rd1 == tail) begin
      rd_instr1 = push_instr0;
      rd_pc1    = push_pc0;
    end else if (wr1 && rd1 == tail_p1) begin
      rd_instr1 = push_instr1;
      rd_pc1    = push_pc1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      push_ready <= 1'b1;
      out_valid  <= 2'b00;
    end else begin
      head       <= head_next;
      tail       <= tail_next;
      count      <= count_next;
      push_ready <= (CNT_W'(DEPTH) - count_next) >= CNT_W'(2);
      out_valid  <= {count_next >= CNT_W'(2), count_next != '0};
    end
  end

  // Entry storage and head data registers carry no reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr0) begin
      instr_mem[tail] <= push_instr0;
      pc_mem[tail]    <= push_pc0;
    end
    if (rst_n && wr1) begin
      instr_mem[tail_p1] <= push_instr1;
      pc_mem[tail_p1]    <= push_pc1;
    end
    out_instr0 <= rd_instr0;
    out_instr1 <= rd_instr1;
    out_pc0    <= rd_pc0;
    out_pc1    <= rd_pc1;
  end

`ifndef SYNTHESIS
  a_push_valid_legal: assert property (@(posedge clk) disable iff (!rst_n)
    push_valid != 2'b10)
    else $error("instr_queue: push_valid=2'b10 is illegal");

  a_pop_num_legal: assert property (@(posedge clk) disable iff (!rst_n)
    pop_num != 2'b11)
    else $error("instr_queue: pop_num=3 is illegal");

  a_pop_within_count: assert property (@(posedge clk) disable iff (!rst_n || flush)
    CNT_W'(pop_num) <= count)
    else $error("instr_queue: pop_num exceeds count");
`endif

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue: a queue-based reference model predicts each
// cycle's outputs; a separate monitor compares them after every rising edge.
module tb_instr_queue;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  push_valid = 2'b00;
  logic [31:0] push_instr0 = '0, push_instr1 = '0, push_pc0 = '0, push_pc1 = '0;
  logic        push_ready;
  logic [1:0]  out_valid;
  logic [31:0] out_instr0, out_instr1, out_pc0, out_pc1;
  logic [1:0]  pop_num = 2'b00;
  logic [3:0]  count;

  instr_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .push_valid(push_valid),
    .push_instr0(push_instr0), .push_instr1(push_instr1),
    .push_pc0(push_pc0), .push_pc1(push_pc1), .push_ready(push_ready),
    .out_valid(out_valid), .out_instr0(out_instr0), .out_instr1(out_instr1),
    .out_pc0(out_pc0), .out_pc1(out_pc1), .pop_num(pop_num), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  cnt;
    logic [1:0]  vld;
    logic        rdy;
    logic [31:0] i0, p0, i1, p1;
  } snap_t;

  snap_t       exp_q[$];
  string       name_q[$];
  logic [63:0] model[$];   // {instr, pc}, index 0 is oldest
  int          vectors = 0;
  int          miscompares = 0;

  // Apply one cycle of stimulus and queue the predicted post-edge outputs.
  task automatic step(input string name, input logic r, input logic f,
                      input logic [1:0] pv, input logic [1:0] pop,
                      input logic [31:0] i0, input logic [31:0] p0,
                      input logic [31:0] i1, input logic [31:0] p1);
    snap_t s;
    int    np;
    bit    rdy;
    @(negedge clk);
    rst_n = r; flush = f; push_valid = pv; pop_num = pop;
    push_instr0 = i0; push_pc0 = p0; push_instr1 = i1; push_pc1 = p1;
    if (!r || f) begin
      model.delete();
    end else begin
      rdy = (int'(DEPTH) - model.size()) >= 2;
      np  = (pop == 2'd3) ? 2 : int'(pop);
      if (np > model.size()) np = model.size();
      repeat (np) void'(model.pop_front());
      if (rdy && pv == 2'b01) model.push_back({i0, p0});
      if (rdy && pv == 2'b11) begin
        model.push_back({i0, p0});
        model.push_back({i1, p1});
      end
    end
    s = '0;
    s.cnt = 4'(model.size());
    s.rdy = (int'(DEPTH) - model.size()) >= 2;
    s.vld = (model.size() >= 2) ? 2'b11 : (model.size() == 1) ? 2'b01 : 2'b00;
    if (model.size() >= 1) {s.i0, s.p0} = model[0];
    if (model.size() >= 2) {s.i1, s.p1} = model[1];
    exp_q.push_back(s);
    name_q.push_back(name);
  endtask

  task automatic push2(input string name, input logic [31:0] pc);
    step(name, 1'b1, 1'b0, 2'b11, 2'd0, $urandom, pc, $urandom, pc + 32'd4);
  endtask

  task automatic push1(input string name, input logic [31:0] pc);
    step(name, 1'b1, 1'b0, 2'b01, 2'd0, $urandom, pc, $urandom, pc + 32'd4);
  endtask

  task automatic idle(input string name, input logic [1:0] pop);
    step(name, 1'b1, 1'b0, 2'b00, pop, '0, '0, '0, '0);
  endtask

  // Monitor: compare DUT outputs against the oldest outstanding prediction.
  snap_t e;
  string n;
  bit    ok;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      vectors++;
      ok = (count === e.cnt) && (out_valid === e.vld) && (push_ready === e.rdy);
      if (e.vld[0]) ok = ok && (out_instr0 === e.i0) && (out_pc0 === e.p0);
      if (e.vld[1]) ok = ok && (out_instr1 === e.i1) && (out_pc1 === e.p1);
      if (!ok) begin
        miscompares++;
        $display("FAIL %s: got cnt=%0d vld=%b rdy=%b i0=%h p0=%h i1=%h p1=%h, expected cnt=%0d vld=%b rdy=%b i0=%h p0=%h i1=%h p1=%h",
                 n, count, out_valid, push_ready, out_instr0, out_pc0, out_instr1, out_pc1,
                 e.cnt, e.vld, e.rdy, e.i0, e.p0, e.i1, e.p1);
      end
    end
  end

  initial begin
    int          hi;
    logic        r, f;
    logic [1:0]  pv, pop;

    step("reset0", 1'b0, 1'b0, 2'b00, 2'd0, '0, '0, '0, '0);
    step("reset1", 1'b0, 1'b0, 2'b00, 2'd0, '0, '0, '0, '0);

    step("basic_push", 1'b1, 1'b0, 2'b11, 2'd0,
         32'h24020001, 32'h1000, 32'h24030002, 32'h1004);
    idle("basic_pop1", 2'd1);
    idle("basic_pop_last", 2'd1);

    for (int k = 0; k < 4; k++) push2("fill", 32'h2000 + 32'(k * 8));
    push2("fill_over", 32'h2100);
    idle("fill_hold", 2'd0);
    for (int k = 0; k < 4; k++) idle("drain", 2'd2);

    for (int k = 0; k < 3; k++) push2("prewrap", 32'h3000 + 32'(k * 8));
    push1("prewrap1", 32'h3018);
    for (int k = 0; k < 3; k++) idle("prewrap_pop", 2'd2);
    idle("prewrap_pop1", 2'd1);
    push2("wrap_push", 32'h4000);
    idle("wrap_pop", 2'd2);

    push2("simul_fill", 32'h5000);
    push1("simul_fill1", 32'h5008);
    step("simul", 1'b1, 1'b0, 2'b11, 2'd2, $urandom, 32'h500c, $urandom, 32'h5010);
    idle("simul_after", 2'd0);

    push2("flush_fill", 32'h6000);
    step("flush", 1'b1, 1'b1, 2'b11, 2'd2, $urandom, 32'h6008, $urandom, 32'h600c);
    idle("flush_after", 2'd0);

    for (int k = 0; k < 3; k++) push2("rst_fill", 32'h7000 + 32'(k * 8));
    step("rst_mid", 1'b0, 1'b0, 2'b11, 2'd1, $urandom, 32'h7100, $urandom, 32'h7104);
    push1("rst_post_push", 32'h7200);
    idle("rst_post_check", 2'd0);

    for (int k = 0; k < 400; k++) begin
      r  = ($urandom % 60) != 0;
      f  = ($urandom % 40) == 0;
      case ($urandom % 3)
        0:       pv = 2'b00;
        1:       pv = 2'b01;
        default: pv = 2'b11;
      endcase
      hi  = (model.size() < 2) ? model.size() : 2;
      pop = 2'($urandom_range(0, hi));
      step("random", r, f, pv, pop, $urandom, $urandom, $urandom, $urandom);
    end

    idle("final", 2'd0);
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d predictions left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
